// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants and types for the button interrupt controller
package irq_ctrl_pkg;

    localparam int DEF_NUM_SRC         = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 16000;

    localparam logic [4:0] OFF_STATUS  = 5'h00;
    localparam logic [4:0] OFF_PENDING = 5'h04;
    localparam logic [4:0] OFF_MASK    = 5'h08;
    localparam logic [4:0] OFF_EDGE    = 5'h0C;
    localparam logic [4:0] OFF_ACTIVE  = 5'h10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/irq_ctrl_btn_debounce.sv
// rtl/irq_ctrl_btn_debounce.sv - two-flop synchronizer plus stable-level debounce counter
module btn_debounce
    import irq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_in,
    output logic level
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped button interrupt controller with fixed-priority arbiter
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_SRC         = DEF_NUM_SRC,
    parameter int          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [31:0] BASE_ADDR       = 32'h0300_0000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] btn_in,
    input  logic               mem_valid,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_wstrb,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata,
    output logic [NUM_SRC-1:0] irq_n
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] level;
    logic [NUM_SRC-1:0] level_prev_q, level_prev_d;
    logic [NUM_SRC-1:0] edge_hit;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] esel_q, esel_d;
    logic [NUM_SRC-1:0] irq_n_q, irq_n_d;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] wbits;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   lowest;
    arb_state_e         state_q, state_d;

    logic               mem_ready_q, mem_ready_d;
    logic               acked_q, acked_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        rd_val;
    logic [4:0]         off;
    logic               in_win, req, wr_en;
    logic               unused_wdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .resetn (resetn),
            .btn_in (btn_in[g]),
            .level  (level[g])
        );
    end

    assign level_prev_d = level;

    always_comb begin
        edge_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            edge_hit[i] = esel_q[i] ? (level_prev_q[i] & ~level[i])
                                    : (~level_prev_q[i] & level[i]);
        end
    end

    // acked_q holds off a second acknowledge while the CPU keeps mem_valid up.
    assign in_win       = (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign req          = mem_valid && in_win && !mem_ready_q && !acked_q;
    assign wr_en        = req && mem_wstrb[0];
    assign off          = mem_addr[4:0];
    assign wbits        = mem_wdata[NUM_SRC-1:0];
    assign unused_wdata = ^mem_wdata[31:NUM_SRC];

    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            active[i] = (state_q == ST_GRANT) && (grant_q == IDX_W'(i));
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_STATUS:  rd_val[NUM_SRC-1:0] = level;
            OFF_PENDING: rd_val[NUM_SRC-1:0] = pend_q;
            OFF_MASK:    rd_val[NUM_SRC-1:0] = mask_q;
            OFF_EDGE:    rd_val[NUM_SRC-1:0] = esel_q;
            OFF_ACTIVE:  rd_val[NUM_SRC-1:0] = active;
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        mem_ready_d = req;
        acked_d     = mem_valid && (acked_q || req);
        rdata_d     = (req && (mem_wstrb == 4'b0000)) ? rd_val : '0;
    end

    // Edge set is OR-ed in after the clear so a simultaneous new edge survives the W1C.
    always_comb begin
        mask_d = mask_q;
        esel_d = esel_q;
        pend_d = pend_q;
        if (wr_en) begin
            case (off)
                OFF_MASK:    mask_d = wbits;
                OFF_EDGE:    esel_d = wbits;
                OFF_PENDING: pend_d = pend_q & ~wbits;
                default:     ;
            endcase
        end
        pend_d = pend_d | edge_hit;
    end

    always_comb begin
        req_vec = pend_q & mask_q;
        lowest  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                lowest = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        irq_n_d = irq_n_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_d         = ST_GRANT;
                    grant_d         = lowest;
                    irq_n_d         = '1;
                    irq_n_d[lowest] = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!pend_q[grant_q] || !mask_q[grant_q]) begin
                    state_d = ST_IDLE;
                    irq_n_d = '1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_prev_q <= '0;
            pend_q       <= '0;
            mask_q       <= '0;
            esel_q       <= '0;
            irq_n_q      <= '1;
            grant_q      <= '0;
            state_q      <= ST_IDLE;
            mem_ready_q  <= 1'b0;
            acked_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            level_prev_q <= level_prev_d;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            esel_q       <= esel_d;
            irq_n_q      <= irq_n_d;
            grant_q      <= grant_d;
            state_q      <= state_d;
            mem_ready_q  <= mem_ready_d;
            acked_q      <= acked_d;
            rdata_q      <= rdata_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = rdata_q;
    assign irq_n     = irq_n_q;

endmodule
